// File: rtl/bmult_dot_acc.sv
// Dot-product accumulator behind the 6x6 multiplier: sums N_TERMS products and hands the result out on a valid/ready port.
// Build option: define BMULT_DOT_ACC_SAT_EN for saturating adds and the sat_flag output.
//
// state   | meaning
// S_ACCUM | no result held, sum_out is stale
// S_FULL  | result held on sum_out, waiting for sum_ready
module bmult_dot_acc #(
    parameter int PW      = 12,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 14,
    localparam int CW     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PW-1:0]    p_in,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [CW-1:0]    term_cnt
`ifdef BMULT_DOT_ACC_SAT_EN
    ,
    output logic             sat_flag
`endif
);

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_sum;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_drain;
    logic             w_last;
    logic             w_complete;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_sum;

    assign w_p_ext    = ACC_W'(p_in);
    assign w_base     = (r_cnt == '0) ? '0 : r_acc;
    assign w_last     = (r_cnt == CW'(N_TERMS - 1));
    assign p_ready    = (r_state == S_ACCUM) | sum_ready;
    assign w_accept   = p_valid & p_ready;
    assign w_drain    = (r_state == S_FULL) & sum_ready;
    assign w_complete = w_accept & w_last & ~clear;

`ifdef BMULT_DOT_ACC_SAT_EN
    logic             r_sat_part;
    logic             r_sat_flag;
    logic [ACC_W:0]   w_raw;
    logic [PW-1:0]    w_p_hi;
    logic             w_sat;
    logic             w_sat_any;

    // A product wider than the accumulator also counts as saturating.
    assign w_p_hi    = p_in >> ACC_W;
    assign w_raw     = {1'b0, w_base} + {1'b0, w_p_ext};
    assign w_sat     = w_raw[ACC_W] | (|w_p_hi);
    assign w_sum     = w_sat ? '1 : w_raw[ACC_W-1:0];
    assign w_sat_any = w_sat | ((r_cnt != '0) & r_sat_part);
    assign sat_flag  = r_sat_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_part <= 1'b0;
            r_sat_flag <= 1'b0;
        end else if (clear) begin
            r_sat_part <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_sat_flag <= w_sat_any;
                r_sat_part <= 1'b0;
            end else begin
                r_sat_part <= w_sat_any;
            end
        end
    end
`else
    assign w_sum = w_base + w_p_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else begin
            // clear aborts only the partial sum; a held result is untouched
            if (clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_sum <= w_sum;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            case (r_state)
                S_ACCUM: if (w_complete) r_state <= S_FULL;
                S_FULL:  if (w_drain && !w_complete) r_state <= S_ACCUM;
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign sum_valid = (r_state == S_FULL);
    assign sum_out   = r_sum;
    assign term_cnt  = r_cnt;

endmodule

// File: tb/tb_bmult_dot_acc.sv
// Scoreboard bench for bmult_dot_acc: a list-based reference model predicts results, a monitor checks each drained one.
module tb_bmult_dot_acc;
    localparam int PW = 12;
    localparam int N  = 4;
    localparam int AW = 14;
    localparam int CW = 2;
    localparam longint MAXV = (64'd1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] p_in = '0;
    logic          p_valid = 1'b0;
    logic          clear = 1'b0;
    logic          sum_ready = 1'b0;
    wire           p_ready;
    wire           sum_valid;
    wire [AW-1:0]  sum_out;
    wire [CW-1:0]  term_cnt;
`ifdef BMULT_DOT_ACC_SAT_EN
    wire           sat_flag;
`endif

    bmult_dot_acc #(.PW(PW), .N_TERMS(N), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
        .clear(clear), .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .term_cnt(term_cnt)
`ifdef BMULT_DOT_ACC_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: products of the current group, results still owed downstream.
    longint terms[$];
    longint exp_q[$];
    bit     exp_sat_q[$];
    bit     m_full = 1'b0;
    bit     m_accept = 1'b0;
    longint last_sum = -1;
    int     drains = 0;

    task automatic model_reset();
        terms.delete();
        exp_q.delete();
        exp_sat_q.delete();
        m_full = 1'b0;
        m_accept = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            bit rdy;
            longint total;
            chk("term_cnt", term_cnt, terms.size());
            chk("sum_valid", sum_valid, m_full);
            rdy = !m_full || sum_ready;
            chk("p_ready", p_ready, rdy);
            m_accept = p_valid && rdy;
            if (m_full && sum_ready) m_full = 1'b0;
            if (clear) begin
                terms.delete();
            end else if (m_accept) begin
                terms.push_back(longint'(p_in));
                if (terms.size() == N) begin
                    total = 0;
                    foreach (terms[k]) total += terms[k];
`ifdef BMULT_DOT_ACC_SAT_EN
                    exp_sat_q.push_back(total > MAXV);
                    exp_q.push_back(total > MAXV ? MAXV : total);
`else
                    exp_sat_q.push_back(1'b0);
                    exp_q.push_back(total % (MAXV + 1));
`endif
                    terms.delete();
                    m_full = 1'b1;
                end
            end
        end else begin
            m_accept = 1'b0;
        end
    end

    // Monitor: every drain handshake must deliver the oldest owed result.
    always @(negedge clk) begin
        if (rst_n && sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got %0d expected none at %0t", sum_out, $time);
            end else begin
                longint e;
                bit es;
                e = exp_q.pop_front();
                es = exp_sat_q.pop_front();
                chk("sum_out", sum_out, e);
`ifdef BMULT_DOT_ACC_SAT_EN
                chk("sat_flag", sat_flag, es);
`else
                if (es) $display("note: unexpected sat expectation");
`endif
                last_sum = sum_out;
                drains++;
            end
        end
    end

    task automatic offer(input logic [PW-1:0] v);
        int budget;
        budget = 0;
        p_valid = 1'b1;
        p_in = v;
        do begin
            @(posedge clk);
            budget++;
        end while (!m_accept && budget < 50);
        if (!m_accept) begin
            n_chk++;
            $display("FAIL offer_timeout: got no accept expected accept of %0d", v);
        end
        #1;
    endtask

    task automatic idle(input int n);
        p_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int d0;
        model_reset();
        #12;
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_p_ready", p_ready, 1);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_term_cnt", term_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1+2+3+4, one-cycle result
        sum_ready = 1'b1;
        for (int i = 1; i <= 4; i++) offer(i[PW-1:0]);
        p_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", sum_valid, 1);
        chk("t1_sum", sum_out, 10);
        @(negedge clk);
        chk("t1_one_cycle", sum_valid, 0);
        @(posedge clk); #1;

        // 4 x 3969
        for (int i = 0; i < 4; i++) offer(12'd3969);
        idle(2);
        chk("t2_sum", last_sum, 15876);

        // backpressure
        sum_ready = 1'b0;
        for (int i = 1; i <= 4; i++) offer(i[PW-1:0]);
        p_valid = 1'b1;
        p_in = 12'd5;
        repeat (3) begin
            @(negedge clk);
            chk("t3_hold_sum", sum_out, 10);
            chk("t3_hold_ready", p_ready, 0);
            chk("t3_not_taken", term_cnt, 0);
        end
        @(posedge clk); #1;
        sum_ready = 1'b1;
        d0 = drains;
        offer(12'd5);
        p_valid = 1'b0;
        @(negedge clk);
        chk("t3_drained", drains - d0, 1);
        chk("t3_taken", term_cnt, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) offer(12'd0);
        idle(2);
        chk("t3_tail_sum", last_sum, 5);

        // continuous 1..8, no bubble
        d0 = drains;
        t0 = 0;
        for (int i = 1; i <= 8; i++) begin
            offer(i[PW-1:0]);
            t0++;
        end
        idle(2);
        chk("t4_results", drains - d0, 2);
        chk("t4_last", last_sum, 26);

        // clear drops partial and the same-cycle product
        offer(12'd5);
        offer(12'd6);
        p_valid = 1'b1;
        p_in = 12'd7;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        p_valid = 1'b0;
        @(negedge clk);
        chk("t5_cleared", term_cnt, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) offer(12'd1);
        idle(2);
        chk("t5_sum", last_sum, 4);

        // async reset mid-group
        for (int i = 0; i < 3; i++) offer(12'd9);
        p_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_valid", sum_valid, 0);
        chk("t6_rst_cnt", term_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) offer(12'd2);
        idle(2);
        chk("t6_sum", last_sum, 8);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if (!(p_valid && !m_accept)) begin
                p_valid = ($urandom_range(0, 3) != 0);
                p_in = PW'($urandom_range(0, 4095));
            end
            sum_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        clear = 1'b0;
        p_valid = 1'b0;
        sum_ready = 1'b1;
        idle(4);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL owed_results: got %0d left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
